// File: rtl/mem_xfer_sequencer_if.sv
// Handshake and strobe bundle between the datapath top level and mem_xfer_sequencer.
interface mem_xfer_sequencer_if #(
  parameter int CNT_W = 5
);
  logic             start;
  logic             hold;
  logic             WEA;
  logic             WEB;
  logic             IncA;
  logic             IncB;
  logic [CNT_W-1:0] step;
  logic             busy;
  logic             done;

  modport master (output start, hold, input WEA, WEB, IncA, IncB, step, busy, done);
  modport slave  (input start, hold, output WEA, WEB, IncA, IncB, step, busy, done);
endinterface

// File: rtl/mem_xfer_sequencer.sv
// Self-timed A-load / gap / B-write-pair schedule with start/busy/done and hold.
module mem_xfer_sequencer #(
  parameter int LOAD_LEN = 8,
  parameter int GAP_LEN  = 2,
  parameter int PAIRS    = 4,
  parameter int CNT_W    = 5
) (
  input  logic                 clk,
  input  logic                 Reset_n,
  mem_xfer_sequencer_if.slave  bus
);
  localparam int T = 1 + LOAD_LEN + GAP_LEN + 2*PAIRS;
  localparam logic [CNT_W-1:0] LOAD_END = CNT_W'(LOAD_LEN);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(LOAD_LEN + GAP_LEN);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(T - 1);

  if ((2**CNT_W) < T) begin : g_cnt_chk
    $error("mem_xfer_sequencer: CNT_W too small for schedule length");
  end

  typedef enum logic [2:0] {IDLE, PRIME, LOAD, GAP, PAIR_W, PAIR_I} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic             wea_q, web_q, inca_q, incb_q, busy_q, done_q;
  logic             frozen;

  // {WEA, WEB, IncA, IncB} issued for the step entered in a given state
  function automatic logic [3:0] strobes(state_e s);
    case (s)
      PRIME, GAP: strobes = 4'b0010;
      LOAD:       strobes = 4'b1010;
      PAIR_W:     strobes = 4'b0110;
      PAIR_I:     strobes = 4'b0011;
      default:    strobes = 4'b0000;
    endcase
  endfunction

  assign frozen = bus.hold && (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    step_d  = step_q + CNT_W'(1);
    case (state_q)
      IDLE:    begin
                 state_d = bus.start ? PRIME : IDLE;
                 step_d  = '0;
               end
      PRIME:   state_d = LOAD;
      LOAD:    if (step_q == LOAD_END) state_d = (GAP_LEN > 0) ? GAP : PAIR_W;
      GAP:     if (step_q == GAP_END) state_d = PAIR_W;
      PAIR_W:  state_d = PAIR_I;
      PAIR_I:  state_d = (step_q == LAST) ? IDLE : PAIR_W;
      default: state_d = IDLE;
    endcase
    if (frozen) begin
      state_d = state_q;
      step_d  = step_q;
    end
    if (state_d == IDLE) step_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      {wea_q, web_q, inca_q, incb_q} <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      // a held step keeps its index but its strobes are never re-issued
      {wea_q, web_q, inca_q, incb_q} <= frozen ? 4'b0000 : strobes(state_d);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_q == PAIR_I) && (state_d == IDLE);
    end
  end

  assign bus.WEA  = wea_q;
  assign bus.WEB  = web_q;
  assign bus.IncA = inca_q;
  assign bus.IncB = incb_q;
  assign bus.step = step_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_mem_xfer_sequencer.sv
// Directed bench: default schedule on one instance, short no-gap schedule on another.
module tb_mem_xfer_sequencer;
  logic clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_xfer_sequencer_if #(.CNT_W(5)) ia();
  mem_xfer_sequencer_if #(.CNT_W(4)) ib();

  mem_xfer_sequencer ua (.clk(clk), .Reset_n(Reset_n), .bus(ia.slave));
  mem_xfer_sequencer #(.LOAD_LEN(3), .GAP_LEN(0), .PAIRS(2), .CNT_W(4))
    ub (.clk(clk), .Reset_n(Reset_n), .bus(ib.slave));

  int nvec = 0;
  int nerr = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // legacy map, {WEA,WEB,IncA,IncB}
  function automatic logic [3:0] exp_a(int s);
    if (s == 0)       return 4'b0010;
    if (s <= 8)       return 4'b1010;
    if (s <= 10)      return 4'b0010;
    if (s % 2 == 1)   return 4'b0110;
    return 4'b0011;
  endfunction

  function automatic logic [3:0] exp_b(int s);
    if (s == 0)       return 4'b0010;
    if (s <= 3)       return 4'b1010;
    if (s % 2 == 0)   return 4'b0110;
    return 4'b0011;
  endfunction

  task automatic look(bit b, int s, logic [3:0] st, logic bz, logic dn);
    string p;
    p = b ? "B" : "A";
    if (!b) begin
      chk($sformatf("%s.step@%0d", p, s), 32'(ia.step), s);
      chk($sformatf("%s.strobes@%0d", p, s), 32'({ia.WEA, ia.WEB, ia.IncA, ia.IncB}), 32'(st));
      chk($sformatf("%s.busy@%0d", p, s), 32'(ia.busy), 32'(bz));
      chk($sformatf("%s.done@%0d", p, s), 32'(ia.done), 32'(dn));
    end else begin
      chk($sformatf("%s.step@%0d", p, s), 32'(ib.step), s);
      chk($sformatf("%s.strobes@%0d", p, s), 32'({ib.WEA, ib.WEB, ib.IncA, ib.IncB}), 32'(st));
      chk($sformatf("%s.busy@%0d", p, s), 32'(ib.busy), 32'(bz));
      chk($sformatf("%s.done@%0d", p, s), 32'(ib.done), 32'(dn));
    end
  endtask

  task automatic set_start(bit b, logic v);
    if (b) ib.start = v; else ia.start = v;
  endtask

  task automatic set_hold(bit b, logic v);
    if (b) ib.hold = v; else ia.hold = v;
  endtask

  task automatic launch(bit b);
    set_start(b, 1'b1);
    @(negedge clk);
    set_start(b, 1'b0);
  endtask

  // entered on the negedge showing step 0; leaves one cycle after the done pulse
  task automatic run(bit b, int hold_at, int hold_len, int dup_at, bit b2b);
    int last;
    last = b ? 7 : 18;
    for (int s = 0; s <= last; s++) begin
      look(b, s, b ? exp_b(s) : exp_a(s), 1'b1, 1'b0);
      if (s == dup_at) set_start(b, 1'b1);
      if (s == hold_at) begin
        set_hold(b, 1'b1);
        repeat (hold_len) begin
          @(negedge clk);
          look(b, s, 4'b0000, 1'b1, 1'b0);
        end
        set_hold(b, 1'b0);
      end
      @(negedge clk);
      set_start(b, 1'b0);
    end
    look(b, 0, 4'b0000, 1'b0, 1'b1);
    if (b2b) set_start(b, 1'b1);
    @(negedge clk);
    set_start(b, 1'b0);
    if (b2b) look(b, 0, 4'b0010, 1'b1, 1'b0);
    else     look(b, 0, 4'b0000, 1'b0, 1'b0);
  endtask

  // per-run strobe tallies, checked on each done pulse
  int a_inca, a_wea, a_web, a_incb, b_inca, b_wea, b_web, b_incb;
  always @(posedge clk) begin
    #1;
    if (!Reset_n) begin
      a_inca = 0; a_wea = 0; a_web = 0; a_incb = 0;
      b_inca = 0; b_wea = 0; b_web = 0; b_incb = 0;
    end else begin
      chk("A.wea_web_excl", 32'(ia.WEA & ia.WEB), 0);
      chk("B.wea_web_excl", 32'(ib.WEA & ib.WEB), 0);
      a_inca += int'(ia.IncA); a_wea += int'(ia.WEA); a_web += int'(ia.WEB); a_incb += int'(ia.IncB);
      b_inca += int'(ib.IncA); b_wea += int'(ib.WEA); b_web += int'(ib.WEB); b_incb += int'(ib.IncB);
      if (ia.done) begin
        chk("A.run_IncA", a_inca, 19); chk("A.run_WEA", a_wea, 8);
        chk("A.run_WEB", a_web, 4);    chk("A.run_IncB", a_incb, 4);
        a_inca = 0; a_wea = 0; a_web = 0; a_incb = 0;
      end
      if (ib.done) begin
        chk("B.run_IncA", b_inca, 8); chk("B.run_WEA", b_wea, 3);
        chk("B.run_WEB", b_web, 2);   chk("B.run_IncB", b_incb, 2);
        b_inca = 0; b_wea = 0; b_web = 0; b_incb = 0;
      end
    end
  end

  initial begin
    ia.start = 1'b0; ia.hold = 1'b0;
    ib.start = 1'b0; ib.hold = 1'b0;
    Reset_n = 1'b0;
    repeat (2) @(negedge clk);
    look(1'b0, 0, 4'b0000, 1'b0, 1'b0);
    look(1'b1, 0, 4'b0000, 1'b0, 1'b0);
    Reset_n = 1'b1;

    // hold while idle does nothing; start with hold high still issues step 0
    ia.hold = 1'b1;
    repeat (2) @(negedge clk);
    look(1'b0, 0, 4'b0000, 1'b0, 1'b0);
    launch(1'b0);
    run(1'b0, 0, 2, -1, 1'b0);

    // plain default schedule
    launch(1'b0);
    run(1'b0, -1, 0, -1, 1'b0);

    // hold 3 cycles at step 4, stray start at step 6, restart in done cycle
    launch(1'b0);
    run(1'b0, 4, 3, 6, 1'b1);
    run(1'b0, -1, 0, -1, 1'b0);

    // no-gap short schedule
    launch(1'b1);
    run(1'b1, -1, 0, -1, 1'b0);

    // reset at step 12 aborts with no done pulse
    launch(1'b0);
    for (int s = 0; s < 12; s++) begin
      look(1'b0, s, exp_a(s), 1'b1, 1'b0);
      @(negedge clk);
    end
    look(1'b0, 12, exp_a(12), 1'b1, 1'b0);
    Reset_n = 1'b0;
    @(negedge clk);
    look(1'b0, 0, 4'b0000, 1'b0, 1'b0);
    Reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      look(1'b0, 0, 4'b0000, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
